// File: rtl/mura_input_cond.sv
// Four-channel button conditioner: synchronize, debounce, latch rising requests,
// then emit one-hot command pulses to the Moore controller with an idle gap after each.
module mura_input_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    output logic       a0,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic [3:0] pend,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] w_deb;
    logic [3:0] w_pend_set;
    logic [3:0] r_pend;
    logic [3:0] r_a;
    logic [3:0] w_grant;
    logic [3:0] w_clr;
    logic       w_take;
    logic       r_busy;
    logic [2:0] r_gap_cnt;
    state_t     r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'd0;
            r_sync2 <= 4'd0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            logic       r_deb;
            logic [3:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_deb <= 1'b0;
                    r_cnt <= 4'd0;
                end else if (r_sync2[gi] == r_deb) begin
                    r_cnt <= 4'd0;
                end else if (r_cnt == 4'(DEB_CYCLES - 1)) begin
                    r_deb <= ~r_deb;
                    r_cnt <= 4'd0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end

            // Only an accepted 0->1 change of the debounced level raises a request.
            assign w_deb[gi]      = r_deb;
            assign w_pend_set[gi] = r_sync2[gi] & ~r_deb & (r_cnt == 4'(DEB_CYCLES - 1));
        end
    endgenerate

    // Lowest set index wins; with no gap a pulse may directly follow another.
    assign w_grant = r_pend & (~r_pend + 4'd1);
    assign w_take  = (r_pend != 4'd0) &&
                     ((r_state == IDLE) || ((r_state == PULSE) && (GAP_CYCLES == 0)));
    assign w_clr   = w_take ? w_grant : 4'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pend    <= 4'd0;
            r_a       <= 4'd0;
            r_busy    <= 1'b0;
            r_gap_cnt <= 3'd0;
        end else begin
            // A request set on the same edge it is serviced stays pending.
            r_pend <= (r_pend & ~w_clr) | w_pend_set;
            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_state <= PULSE;
                        r_a     <= w_grant;
                        r_busy  <= 1'b1;
                    end else begin
                        r_a    <= 4'd0;
                        r_busy <= 1'b0;
                    end
                end
                PULSE: begin
                    if (w_take) begin
                        r_a    <= w_grant;
                        r_busy <= 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        r_state   <= GAP;
                        r_a       <= 4'd0;
                        r_busy    <= 1'b1;
                        r_gap_cnt <= 3'd0;
                    end else begin
                        r_state <= IDLE;
                        r_a     <= 4'd0;
                        r_busy  <= 1'b0;
                    end
                end
                GAP: begin
                    r_a <= 4'd0;
                    if (r_gap_cnt == 3'(GAP_CYCLES - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_a     <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a0   = r_a[0];
    assign a1   = r_a[1];
    assign a2   = r_a[2];
    assign a3   = r_a[3];
    assign pend = r_pend;
    assign busy = r_busy;

endmodule
